// File: rtl/brick_matrix_writer.sv
// brick_matrix_writer: sole writer of the brick occupancy matrix; clears bricks on bullet hits and reloads levels
// Ports: clk/resetN (sync active-low); topLeftX/Y matrix origin; hitValid/hitReady/hitX/hitY hit handshake;
// loadLevel reload pulse; hitDone/hitDestroyed result pulse; matrix occupancy; bricksLeft/allCleared counts
module brick_matrix_writer #(
  parameter int MATRIX_ROWS = 14,
  parameter int MATRIX_COLS = 17,
  parameter int CELL_LOG2 = 5,
  parameter logic [0:MATRIX_ROWS-1][0:MATRIX_COLS-1] INIT_MATRIX = '1
)(
  input  logic clk,
  input  logic resetN,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic hitValid,
  input  logic [10:0] hitX,
  input  logic [10:0] hitY,
  output logic hitReady,
  input  logic loadLevel,
  output logic hitDone,
  output logic hitDestroyed,
  output logic [0:MATRIX_ROWS-1][0:MATRIX_COLS-1] matrix,
  output logic [7:0] bricksLeft,
  output logic allCleared
);
  localparam int RW = $clog2(MATRIX_ROWS);
  localparam int CW = $clog2(MATRIX_COLS);
  localparam logic [7:0] INIT_LEFT = 8'($countones(INIT_MATRIX));
  localparam logic [11:0] X_LIM = 12'(MATRIX_COLS << CELL_LOG2);
  localparam logic [11:0] Y_LIM = 12'(MATRIX_ROWS << CELL_LOG2);
  typedef enum logic [1:0] {IDLE, DECODE, UPDATE} state_t;
  state_t state, state_n;
  logic [11:0] rel_x, rel_y;
  logic raw_in, in_range, accept, hit;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  always_ff @(posedge clk)
    if (!resetN) state <= IDLE;
    else state <= state_n;
  // loadLevel blocks acceptance so a reload never races a new capture
  always_comb begin
    hitReady = state == IDLE && !loadLevel;
    accept = hitValid && hitReady;
    state_n = loadLevel ? IDLE :
              state == IDLE ? (accept ? DECODE : IDLE) :
              state == DECODE ? UPDATE : IDLE;
  end
  // in_range guards the lookup, so stale row/col beyond the matrix are never used
  assign hit = in_range && matrix[row][col];
  assign allCleared = bricksLeft == 8'd0;
  always_ff @(posedge clk)
    if (!resetN) begin
      matrix <= INIT_MATRIX;
      bricksLeft <= INIT_LEFT;
      hitDone <= 1'b0;
      hitDestroyed <= 1'b0;
    end else begin
      hitDone <= 1'b0;
      hitDestroyed <= 1'b0;
      if (loadLevel) begin
        matrix <= INIT_MATRIX;
        bricksLeft <= INIT_LEFT;
      end else begin
        if (accept) begin
          rel_x <= {1'b0, hitX} - {1'b0, topLeftX};
          rel_y <= {1'b0, hitY} - {1'b0, topLeftY};
          raw_in <= hitX >= topLeftX && hitY >= topLeftY;
        end
        if (state == DECODE) begin
          in_range <= raw_in && rel_x < X_LIM && rel_y < Y_LIM;
          row <= RW'(rel_y >> CELL_LOG2);
          col <= CW'(rel_x >> CELL_LOG2);
        end
        if (state == UPDATE) begin
          hitDone <= 1'b1;
          hitDestroyed <= hit;
          if (hit) begin
            matrix[row][col] <= 1'b0;
            bricksLeft <= bricksLeft - 8'd1;
          end
        end
      end
    end
endmodule

// File: tb/tb_brick_matrix_writer.sv
// tb_brick_matrix_writer: randomized self-checking bench for brick_matrix_writer against a cell-arithmetic model
module tb_brick_matrix_writer;
  logic clk = 0, resetN = 0, hitValid = 0, loadLevel = 0;
  logic [10:0] topLeftX = 0, topLeftY = 0, hitX = 0, hitY = 0;
  logic hitReady, hitDone, hitDestroyed, allCleared;
  logic [0:13][0:16] matrix, exp_m;
  logic [7:0] bricksLeft;
  int exp_n, pass_n = 0, total_n = 0;
  typedef struct packed {logic ok, r1, r2, d0, d1, s1, rdy, d2;} obs_t;
  brick_matrix_writer dut (.clk(clk), .resetN(resetN), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .hitValid(hitValid), .hitX(hitX), .hitY(hitY), .hitReady(hitReady), .loadLevel(loadLevel),
    .hitDone(hitDone), .hitDestroyed(hitDestroyed), .matrix(matrix), .bricksLeft(bricksLeft),
    .allCleared(allCleared));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic bit model_hit(int tx, int ty, int x, int y);
    int rx = x - tx, ry = y - ty;
    if (rx < 0 || ry < 0 || rx >= 17 * 32 || ry >= 14 * 32) return 0;
    if (!exp_m[ry / 32][rx / 32]) return 0;
    exp_m[ry / 32][rx / 32] = 0;
    exp_n--;
    return 1;
  endfunction
  function automatic void model_load();
    exp_m = '1;
    exp_n = 238;
  endfunction
  task automatic drive_hit(input int tx, input int ty, input int x, input int y, output obs_t o);
    int n = 0;
    o = '0;
    while (hitReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    o.ok = n < 20;
    topLeftX = 11'(tx); topLeftY = 11'(ty); hitX = 11'(x); hitY = 11'(y); hitValid = 1;
    @(negedge clk);
    hitValid = 0;
    topLeftX = 11'($urandom); topLeftY = 11'($urandom); hitX = 11'($urandom); hitY = 11'($urandom);
    o.r1 = hitReady; o.d0 = hitDone;
    @(negedge clk);
    o.r2 = hitReady; o.d0 = o.d0 | hitDone;
    @(negedge clk);
    o.d1 = hitDone; o.s1 = hitDestroyed; o.rdy = hitReady;
    @(negedge clk);
    o.d2 = hitDone;
  endtask
  task automatic test_reset();
    resetN = 0;
    repeat (2) @(negedge clk);
    resetN = 1;
    model_load();
    total_n++; if (matrix !== exp_m) $display("FAIL reset_matrix got %h want %h", matrix, exp_m); else pass_n++;
    total_n++; if (bricksLeft !== 8'd238) $display("FAIL reset_count got %0d want 238", bricksLeft); else pass_n++;
    total_n++; if (hitReady !== 1'b1) $display("FAIL reset_ready got %b want 1", hitReady); else pass_n++;
    total_n++; if (hitDone !== 1'b0 || hitDestroyed !== 1'b0) $display("FAIL reset_done got %b%b want 00", hitDone, hitDestroyed); else pass_n++;
    total_n++; if (allCleared !== 1'b0) $display("FAIL reset_cleared got %b want 0", allCleared); else pass_n++;
  endtask
  task automatic test_basic();
    obs_t o;
    bit e = model_hit(32, 16, 195, 111);
    drive_hit(32, 16, 195, 111, o);
    total_n++; if (o.ok !== 1'b1) $display("FAIL basic_wait got %b want 1", o.ok); else pass_n++;
    total_n++; if ({o.r1, o.r2} !== 2'b00) $display("FAIL basic_busy got %b%b want 00", o.r1, o.r2); else pass_n++;
    total_n++; if (o.d0 !== 1'b0) $display("FAIL basic_early_done got %b want 0", o.d0); else pass_n++;
    total_n++; if ({o.d1, o.s1, o.rdy} !== 3'b111) $display("FAIL basic_done got %b%b%b want 111", o.d1, o.s1, o.rdy); else pass_n++;
    total_n++; if (o.d2 !== 1'b0) $display("FAIL basic_done_len got %b want 0", o.d2); else pass_n++;
    total_n++; if (matrix[2][5] !== 1'b0 || matrix !== exp_m) $display("FAIL basic_matrix got %h want %h", matrix, exp_m); else pass_n++;
    total_n++; if (bricksLeft !== 8'd237) $display("FAIL basic_count got %0d want 237", bricksLeft); else pass_n++;
    total_n++; if (e !== 1'b1) $display("FAIL basic_model got %b want 1", e); else pass_n++;
  endtask
  task automatic test_repeat();
    obs_t o;
    drive_hit(32, 16, 195, 111, o);
    total_n++; if ({o.d1, o.s1} !== 2'b10) $display("FAIL repeat_done got %b%b want 10", o.d1, o.s1); else pass_n++;
    total_n++; if (bricksLeft !== 8'd237) $display("FAIL repeat_count got %0d want 237", bricksLeft); else pass_n++;
    total_n++; if (matrix !== exp_m) $display("FAIL repeat_matrix got %h want %h", matrix, exp_m); else pass_n++;
  endtask
  task automatic test_boundary();
    int px[4] = '{575, 576, 31, 32};
    int py[4] = '{463, 100, 100, 15};
    bit want[4] = '{1, 0, 0, 0};
    obs_t o;
    bit e;
    for (int i = 0; i < 4; i++) begin
      e = model_hit(32, 16, px[i], py[i]);
      drive_hit(32, 16, px[i], py[i], o);
      total_n++; if (o.d1 !== 1'b1 || o.s1 !== want[i]) $display("FAIL boundary_%0d got done=%b destroyed=%b want 1/%b", i, o.d1, o.s1, want[i]); else pass_n++;
      total_n++; if (matrix !== exp_m || 32'(bricksLeft) !== exp_n) $display("FAIL boundary_state_%0d got %0d want %0d", i, bricksLeft, exp_n); else pass_n++;
      total_n++; if (e !== want[i]) $display("FAIL boundary_model_%0d got %b want %b", i, e, want[i]); else pass_n++;
    end
  endtask
  task automatic test_random();
    obs_t o;
    int tx, ty, x, y;
    bit e;
    for (int i = 0; i < 40; i++) begin
      tx = $urandom_range(0, 300); ty = $urandom_range(0, 300);
      x = tx + $urandom_range(0, 620) - 40; y = ty + $urandom_range(0, 520) - 40;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      e = model_hit(tx, ty, x, y);
      drive_hit(tx, ty, x, y, o);
      total_n++; if (o.d1 !== 1'b1 || o.s1 !== e) $display("FAIL random_%0d (%0d,%0d)@(%0d,%0d) got %b/%b want 1/%b", i, x, y, tx, ty, o.d1, o.s1, e); else pass_n++;
      total_n++; if (matrix !== exp_m || 32'(bricksLeft) !== exp_n) $display("FAIL random_state_%0d got %0d want %0d", i, bricksLeft, exp_n); else pass_n++;
      total_n++; if (allCleared !== (exp_n == 0)) $display("FAIL random_cleared_%0d got %b", i, allCleared); else pass_n++;
    end
  endtask
  task automatic test_load_level();
    logic seen = 0;
    topLeftX = 32; topLeftY = 16; hitX = 100; hitY = 60; hitValid = 1;
    @(negedge clk);
    hitValid = 0; loadLevel = 1;
    @(negedge clk);
    loadLevel = 0;
    #1;
    model_load();
    total_n++; if (hitReady !== 1'b1) $display("FAIL load_ready got %b want 1", hitReady); else pass_n++;
    total_n++; if (matrix !== exp_m) $display("FAIL load_matrix got %h want %h", matrix, exp_m); else pass_n++;
    total_n++; if (bricksLeft !== 8'd238) $display("FAIL load_count got %0d want 238", bricksLeft); else pass_n++;
    for (int i = 0; i < 3; i++) begin seen = seen | hitDone; @(negedge clk); end
    total_n++; if (seen !== 1'b0) $display("FAIL load_abort got %b want 0", seen); else pass_n++;
    hitValid = 1; loadLevel = 1;
    #1;
    total_n++; if (hitReady !== 1'b0) $display("FAIL load_block_ready got %b want 0", hitReady); else pass_n++;
    @(negedge clk);
    hitValid = 0; loadLevel = 0;
    #1;
    total_n++; if (hitReady !== 1'b1) $display("FAIL load_no_accept got %b want 1", hitReady); else pass_n++;
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int cells[238];
    int idx = 0, dones = 0, cyc = 0, last = 0, t, j;
    for (int i = 0; i < 238; i++) cells[i] = i;
    for (int i = 237; i > 0; i--) begin j = $urandom_range(0, i); t = cells[i]; cells[i] = cells[j]; cells[j] = t; end
    loadLevel = 1;
    @(negedge clk);
    loadLevel = 0;
    #1;
    model_load();
    topLeftX = 32; topLeftY = 16;
    while (dones < 238 && cyc < 1000) begin
      if (hitDone === 1'b1) begin
        dones++;
        total_n++; if (hitDestroyed !== 1'b1) $display("FAIL b2b_destroyed_%0d got %b want 1", dones, hitDestroyed); else pass_n++;
        total_n++; if (32'(bricksLeft) !== exp_n) $display("FAIL b2b_count_%0d got %0d want %0d", dones, bricksLeft, exp_n); else pass_n++;
        total_n++; if (allCleared !== (exp_n == 0)) $display("FAIL b2b_cleared_%0d got %b", dones, allCleared); else pass_n++;
        if (dones > 1) begin
          total_n++; if (cyc - last !== 3) $display("FAIL b2b_spacing_%0d got %0d want 3", dones, cyc - last); else pass_n++;
        end
        last = cyc;
      end
      if (hitReady === 1'b1) begin
        if (idx < 238) begin
          hitX = 11'(32 + (cells[idx] % 17) * 32 + $urandom_range(0, 31));
          hitY = 11'(16 + (cells[idx] / 17) * 32 + $urandom_range(0, 31));
          void'(model_hit(32, 16, int'(hitX), int'(hitY)));
          hitValid = 1;
          idx++;
        end else hitValid = 0;
      end
      @(negedge clk);
      cyc++;
    end
    hitValid = 0;
    total_n++; if (dones !== 238) $display("FAIL b2b_done_count got %0d want 238", dones); else pass_n++;
    total_n++; if (bricksLeft !== 8'd0 || allCleared !== 1'b1 || matrix !== '0) $display("FAIL b2b_final got %0d/%b want 0/1", bricksLeft, allCleared); else pass_n++;
  endtask
  task automatic test_reset_mid();
    logic seen = 0;
    topLeftX = 32; topLeftY = 16; hitX = 40; hitY = 20; hitValid = 1;
    @(negedge clk);
    hitValid = 0; resetN = 0;
    @(negedge clk);
    resetN = 1;
    model_load();
    total_n++; if (matrix !== exp_m) $display("FAIL rstmid_matrix got %h want %h", matrix, exp_m); else pass_n++;
    total_n++; if (bricksLeft !== 8'd238 || allCleared !== 1'b0) $display("FAIL rstmid_count got %0d/%b want 238/0", bricksLeft, allCleared); else pass_n++;
    total_n++; if (hitReady !== 1'b1) $display("FAIL rstmid_ready got %b want 1", hitReady); else pass_n++;
    for (int i = 0; i < 3; i++) begin seen = seen | hitDone; @(negedge clk); end
    total_n++; if (seen !== 1'b0) $display("FAIL rstmid_done got %b want 0", seen); else pass_n++;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_repeat();
    test_boundary();
    test_random();
    test_load_level();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/brick_matrix_writer.md
Name: brick_matrix_writer

Overview:
- Owns the 14x17 brick occupancy matrix and is its only writer. The brick renderer and the collision logic read the matrix.
- Accepts bullet-hit pixel coordinates over a valid/ready handshake and converts each one to a cell index.
- Clears the brick at that cell if one is present, tracks the remaining brick count, and reloads the level layout on request.

Parameters:
- MATRIX_ROWS, 14, matrix rows.
- MATRIX_COLS, 17, matrix columns.
- CELL_LOG2, 5, log2 of cell size in pixels (32x32 cells).
- INIT_MATRIX, all ones ([0:13][0:16]), layout loaded at reset and on loadLevel.

Ports:
- clk in 1: system clock.
- resetN in 1: synchronous active-low reset.
- topLeftX in 11: matrix origin X, in pixels.
- topLeftY in 11: matrix origin Y, in pixels.
- hitValid in 1: hit request valid.
- hitX in 11: hit pixel X.
- hitY in 11: hit pixel Y.
- hitReady out 1: block can accept a hit.
- loadLevel in 1: reload INIT_MATRIX; one-cycle pulse.
- hitDone out 1: one-cycle pulse marking the end of a hit transaction.
- hitDestroyed out 1: valid with hitDone; 1 means a brick was cleared.
- matrix out [0:13][0:16]: current occupancy; registered.
- bricksLeft out 8: number of set bits in matrix.
- allCleared out 1: bricksLeft==0.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low on resetN.
- Reset values:
  - matrix=INIT_MATRIX.
  - bricksLeft=popcount(INIT_MATRIX), computed at elaboration (238 with the default).
  - state=IDLE, hitReady=1, hitDone=0, hitDestroyed=0, allCleared=(popcount==0).
- FSM states: IDLE, DECODE, UPDATE.
- IDLE:
  - hitReady=1.
  - On hitValid&&hitReady, capture relX=hitX-topLeftX and relY=hitY-topLeftY (12-bit, with borrow).
  - Also capture inRangeRaw = hitX>=topLeftX && hitY>=topLeftY (unsigned compare). Go to DECODE.
- DECODE:
  - hitReady=0.
  - inRange = inRangeRaw && relX<(MATRIX_COLS<<CELL_LOG2) && relY<(MATRIX_ROWS<<CELL_LOG2), i.e. relX<544 and relY<448.
  - col=relX>>CELL_LOG2, row=relY>>CELL_LOG2; register both. Go to UPDATE.
- UPDATE:
  - hitReady=0.
  - If inRange && matrix[row][col]: clear that bit, decrement bricksLeft, set hitDestroyed<=1.
  - Otherwise leave matrix and bricksLeft unchanged and set hitDestroyed<=0.
  - hitDone<=1. Go to IDLE.
- Latency:
  - The accept edge is E. matrix, bricksLeft, hitDone and hitDestroyed all change at edge E+2, so hitDone is high in the same cycle the new matrix is visible.
  - hitReady is high again in that same cycle.
  - Maximum throughput is one hit per 3 cycles.
- Capture rules: hitX, hitY, topLeftX and topLeftY are sampled only at the accept edge. Later changes do not affect an in-flight transaction.
- hitDone/hitDestroyed: high for exactly one cycle; 0 otherwise.
- loadLevel (highest priority after reset, any state):
  - matrix=INIT_MATRIX, bricksLeft=popcount(INIT_MATRIX), state=IDLE.
  - An in-flight hit is aborted with no hitDone.
  - A hitValid in the same cycle is not accepted (hitReady is forced to 0 that cycle).
- bricksLeft never underflows; a decrement happens only when a set bit is cleared.
- allCleared is derived from the bricksLeft register, so it is asserted in the same cycle bricksLeft becomes 0.
- Reset mid-operation restores all reset values on the next edge; there is no pending hitDone.

Test Plan:
- Basic hit, default INIT, topLeft=(32,16): hit (195,111) → row 2 col 5.
  - At E+2: matrix[2][5]=0, bricksLeft=237, hitDone=1 for 1 cycle, hitDestroyed=1.
  - hitReady=0 in the E+1 and E+2 cycles.
- Repeat hit (195,111) → hitDone=1, hitDestroyed=0, bricksLeft stays 237, matrix unchanged.
- Boundaries with topLeft=(32,16):
  - (575,463) clears [13][16].
  - (576,100) → hitDestroyed=0.
  - (31,100) → hitDestroyed=0.
  - (32,15) → hitDestroyed=0.
  - In all out-of-range cases matrix and count are unchanged.
- Clear all 238 cells back-to-back, with hitValid held high → one accept every 3 cycles. After the last hit: bricksLeft=0 and allCleared=1, in the same cycle as the final hitDone.
- loadLevel asserted in the DECODE cycle of a hit → no hitDone. Next cycle: matrix all ones, bricksLeft=238, hitReady=1.
- resetN=0 for 1 cycle during UPDATE-bound transaction → matrix=INIT, bricksLeft=238, hitDone stays 0, state IDLE.
